// File: rtl/nt_block_builder.sv
// Serial MD4 message-block builder for NT hashing: packs one ASCII candidate as
// UTF-16LE, one char per cycle, then appends the 0x80 pad and the bit length.
module nt_block_builder #(
  parameter int unsigned MAX_LEN = 20,
  parameter int unsigned LEN_W   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*MAX_LEN-1:0]   in_password,
  input  logic [LEN_W-1:0]       in_length,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [511:0]           out_block,
  output logic [LEN_W-1:0]       out_length,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned PW_W  = 8 * MAX_LEN;
  localparam int unsigned BLK_W = 512;

  typedef enum logic [1:0] {IDLE, FILL, PAD, OUT} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_err_q, out_err_d;
  logic [BLK_W-1:0]   out_block_q, out_block_d;
  logic [LEN_W-1:0]   out_length_q, out_length_d;
  logic [PW_W-1:0]    pw_q, pw_d;
  logic [LEN_W-1:0]   idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_block_q  <= '0;
      out_length_q <= '0;
      pw_q         <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_block_q  <= out_block_d;
      out_length_q <= out_length_d;
      pw_q         <= pw_d;
      idx_q        <= idx_d;
    end
  end

  // out_length_q doubles as the latched candidate length for FILL and PAD.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_block_d  = out_block_q;
    out_length_d = out_length_q;
    pw_d         = pw_q;
    idx_d        = idx_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d   = 1'b0;
          out_err_d    = 1'b0;
          out_block_d  = '0;
          out_length_d = in_length;
          pw_d         = in_password;
          idx_d        = '0;
          if (in_length > LEN_W'(MAX_LEN)) begin
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else if (in_length == '0) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (idx_q == LEN_W'(i)) begin
            out_block_d[16*i +: 8]   = pw_q[PW_W-1-8*i -: 8];
            out_block_d[16*i+8 +: 8] = 8'h00;
          end
        end
        idx_d = idx_q + LEN_W'(1);
        if (idx_q == out_length_q - LEN_W'(1)) begin
          state_d = PAD;
        end
      end

      PAD: begin
        for (int i = 0; i <= MAX_LEN; i++) begin
          if (out_length_q == LEN_W'(i)) begin
            out_block_d[16*i +: 8] = 8'h80;
          end
        end
        out_block_d[14*32 +: 32] = 32'(out_length_q) << 4;
        out_block_d[15*32 +: 32] = 32'h0;
        out_valid_d              = 1'b1;
        state_d                  = OUT;
      end

      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_block  = out_block_q;
  assign out_length = out_length_q;

endmodule

// File: tb/tb_nt_block_builder.sv
// Scoreboard bench for nt_block_builder: driver pushes reference-model blocks on
// accept, a negedge monitor compares every presented block, latency and stall.
module tb_nt_block_builder;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int unsigned MAX_LEN = 20;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned PW_W    = 8 * MAX_LEN;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PW_W-1:0]    in_password;
  logic [LEN_W-1:0]   in_length;
  logic               in_valid;
  logic               in_ready;
  logic [511:0]       out_block;
  logic [LEN_W-1:0]   out_length;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  nt_block_builder #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_password(in_password), .in_length(in_length), .in_valid(in_valid),
    .in_ready(in_ready),
    .out_block(out_block), .out_length(out_length), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] blk;
    int           len;
    bit           err;
    longint       t_acc;
  } exp_t;

  exp_t   q[$];
  int     checks   = 0;
  int     failures = 0;
  int     stall_cnt = 0;
  bit     chk_rdy  = 0;
  bit     lat_done = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: NT block = UTF-16LE chars, 0x80, zeros, 64-bit little-endian bit count.
  function automatic logic [511:0] model_block(input int len, input logic [PW_W-1:0] pw);
    logic [7:0]   b [64];
    logic [511:0] blk;
    int unsigned  bits;
    blk = '0;
    if (len > int'(MAX_LEN)) return blk;
    for (int k = 0; k < 64; k++) b[k] = 8'h00;
    for (int i = 0; i < len; i++) b[2*i] = pw[PW_W-1-8*i -: 8];
    b[2*len] = 8'h80;
    bits = 32'(len) * 16;
    b[56] = bits[7:0];
    b[57] = bits[15:8];
    b[58] = bits[23:16];
    b[59] = bits[31:24];
    for (int k = 0; k < 64; k++) blk[8*k +: 8] = b[k];
    return blk;
  endfunction

  task automatic send(input int len, input logic [PW_W-1:0] pw);
    bit   rdy;
    int   n;
    exp_t e;
    @(negedge clk);
    in_valid    = 1'b1;
    in_length   = LEN_W'(len);
    in_password = pw;
    n = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 512'(1), 512'(0));
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.blk   = model_block(len, pw);
    e.len   = len;
    e.err   = (len > int'(MAX_LEN));
    e.t_acc = $time;
    q.push_back(e);
    #1;
    in_valid    = 1'b0;
    in_length   = LEN_W'($urandom);
    in_password = {5{$urandom}};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 512'(q.size()), 512'(0));
  endtask

  // Monitor: compares each presented block, its latency, stall stability and in_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_rdy   = 0;
      lat_done  = 0;
      out_ready = 1'b0;
    end else begin
      if (chk_rdy) begin
        chk("in_ready_after_handshake", 512'(in_ready), 512'(1));
        chk_rdy = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 512'(out_valid), 512'(0));
          out_ready = 1'b1;
        end else begin
          if (!lat_done) begin
            chk("latency", 512'(($time - q[0].t_acc - 5) / 10),
                512'(q[0].err ? 0 : q[0].len + 1));
            lat_done = 1;
          end
          chk("out_block", out_block, q[0].blk);
          chk("out_length", 512'(out_length), 512'(q[0].len));
          chk("out_err", 512'(out_err), 512'(q[0].err));
          chk("in_ready_busy", 512'(in_ready), 512'(0));
          if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
          end else begin
            out_ready = ($urandom_range(0, 2) != 0);
          end
          if (out_ready) begin
            void'(q.pop_front());
            chk_rdy  = 1;
            lat_done = 0;
          end
        end
      end else begin
        out_ready = 1'($urandom);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [PW_W-1:0] pw;
    int              len;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_length   = '0;
    in_password = '0;
    out_ready   = 1'b0;
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_err", 512'(out_err), 512'(0));
    chk("rst_out_block", out_block, 512'(0));
    chk("rst_out_length", 512'(out_length), 512'(0));
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_first_edge", 512'(in_ready), 512'(1));

    pw = '0; pw[PW_W-1 -: 8] = 8'h61;
    send(1, pw);
    send(0, {5{$urandom}});
    send(20, {MAX_LEN{8'h7E}});
    send(21, {5{$urandom}});
    drain();

    stall_cnt = 10;
    pw = '0; pw[PW_W-1 -: 24] = 24'h616263;
    send(3, pw);
    send(5, {5{$urandom}});
    drain();

    // Reset while FILL is at idx 4 of an 8-char candidate.
    send(8, {5{$urandom}});
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_in_ready", 512'(in_ready), 512'(0));
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_out_err", 512'(out_err), 512'(0));
    chk("midrst_out_block", out_block, 512'(0));
    chk("midrst_out_length", 512'(out_length), 512'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready_pre_edge", 512'(in_ready), 512'(0));
    @(posedge clk); #1;
    chk("midrst_in_ready_post_edge", 512'(in_ready), 512'(1));
    repeat (5) @(posedge clk);
    send(7, {5{$urandom}});
    drain();

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(21, 63);
      else                           len = $urandom_range(0, 20);
      send(len, {5{$urandom}});
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
